// File: rtl/inst_mem_bridge_pkg.sv
// Shared types and constants for the instruction memory bridge.
// Also holds the kseg0/kseg1 translation used by both memory bridges.
package inst_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  localparam logic [1:0]  KSEG01_HI  = 2'b10;
  localparam int          KSEG_OFF_W = 29;
  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;

  function automatic logic [31:0] kseg_map(
    input logic [31:0] a
  );
    logic [31:0] p;
    p = a;
    if (a[31:30] == KSEG01_HI)
      p = {{(32-KSEG_OFF_W){1'b0}},
           a[KSEG_OFF_W-1:0]};
    return p;
  endfunction

endpackage

// File: rtl/inst_mem_bridge_if.sv
// SRAM-like split instruction bus: req/addr_ok,
// then data_ok/rdata.
interface inst_mem_bridge_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_mem_bridge_addr_map.sv
// Combinational kseg0/kseg1 virtual-to-physical translation.
// EN=0 passes the address through untouched.
module inst_mem_bridge_addr_map
  import inst_mem_bridge_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [31:0] addr,
  output logic [31:0] paddr
);

  assign paddr = EN ? kseg_map(addr) : addr;

endmodule

// File: rtl/inst_mem_bridge.sv
// Fetch-side bridge onto the instruction bus with a one-entry
// tagged result register so a held PC is served without re-issue.
module inst_mem_bridge
  import inst_mem_bridge_pkg::*;
#(
  parameter bit ADDR_MAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_en,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  inst_mem_bridge_if.master bus
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] req_pc;
  logic [31:0] tag_q;
  logic [31:0] data_q;
  logic        vld_q;
  logic [31:0] map_addr;

  logic hit;
  logic fill;
  logic launch;
  logic relaunch;
  logic bypass;

  assign hit      = vld_q && (tag_q == pc);
  assign fill     = (state_q == WAIT)
                  && bus.inst_data_ok;
  assign launch   = (state_q == IDLE)
                  && pc_en && !hit;
  assign relaunch = fill && pc_en
                  && (pc != req_pc);
  assign bypass   = fill && (req_pc == pc);

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (launch)
          state_d = REQ;
      REQ:
        if (bus.inst_addr_ok)
          state_d = WAIT;
      WAIT:
        if (bus.inst_data_ok)
          state_d = relaunch ? REQ : IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // The fill always lands under req_pc, even after a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc <= '0;
      tag_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (launch || relaunch)
        req_pc <= pc;
      if (fill) begin
        tag_q  <= req_pc;
        data_q <= bus.inst_rdata;
        vld_q  <= 1'b1;
      end
    end
  end

  inst_mem_bridge_addr_map #(
    .EN (ADDR_MAP_EN)
  ) u_addr_map (
    .addr  (req_pc),
    .paddr (map_addr)
  );

  always_comb begin
    bus.inst_req  = (state_q == REQ);
    bus.inst_addr = map_addr;
    inst_o        = data_q;
    inst_valid_o  = pc_en && hit;
    unique case (1'b1)
      bypass: begin
        inst_o       = bus.inst_rdata;
        inst_valid_o = pc_en;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inst_mem_bridge.sv
// Directed bench for inst_mem_bridge with a queue scoreboard
// for accepted requests and delivered instructions.
module tb_inst_mem_bridge;
  import inst_mem_bridge_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic [31:0] pc1;
  logic        pc_en1;
  logic [31:0] inst_o1;
  logic        inst_valid_o1;

  always #5 clk = ~clk;

  inst_mem_bridge_if bus ();
  inst_mem_bridge_if bus1 ();

  inst_mem_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_en        (pc_en),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .bus          (bus)
  );

  inst_mem_bridge #(
    .ADDR_MAP_EN (1'b0)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc1),
    .pc_en        (pc_en1),
    .inst_o       (inst_o1),
    .inst_valid_o (inst_valid_o1),
    .bus          (bus1)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr[$];
  resp_t       exp_inst[$];

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               name, act, exp);
    end
  endtask

  // Monitor: pops on accepted requests and on each new valid fetch.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc    = '0;
  logic [31:0] mon_a;
  resp_t       mon_r;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.inst_req && bus.inst_addr_ok) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_req got %h want none",
                   bus.inst_addr);
        end else begin
          mon_a = exp_addr.pop_front();
          chk("req_addr", bus.inst_addr, mon_a);
        end
      end
      if (inst_valid_o
          && !(prev_valid && prev_pc == pc)) begin
        if (exp_inst.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_valid got %h want none",
                   inst_o);
        end else begin
          mon_r = exp_inst.pop_front();
          chk("resp_pc", pc, mon_r.pc);
          chk("resp_inst", inst_o, mon_r.inst);
        end
      end
    end
    prev_valid = inst_valid_o;
    prev_pc    = pc;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(
    input logic        aok,
    input logic        dok,
    input logic [31:0] rd
  );
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = rd;
  endtask

  task automatic push_inst(
    input logic [31:0] p,
    input logic [31:0] i
  );
    resp_t r;
    r.pc   = p;
    r.inst = i;
    exp_inst.push_back(r);
  endtask

  initial begin
    rst    = 1'b1;
    pc     = '0;
    pc_en  = 1'b0;
    pc1    = '0;
    pc_en1 = 1'b0;
    drive(1'b0, 1'b0, '0);
    bus1.inst_addr_ok = 1'b0;
    bus1.inst_data_ok = 1'b0;
    bus1.inst_rdata   = '0;
    repeat (2) cyc();
    rst = 1'b0;
    smp();
    chk("rst_req", 32'(bus.inst_req), 32'd0);
    chk("rst_addr", bus.inst_addr, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);

    // first fetch from reset vector
    cyc();
    pc     = RESET_PC;
    pc_en  = 1'b1;
    pc1    = 32'h8000_1000;
    pc_en1 = 1'b1;
    exp_addr.push_back(32'h1FC0_0000);
    push_inst(RESET_PC, 32'h2408_0001);
    smp();
    chk("first_n_req", 32'(bus.inst_req), 32'd0);
    cyc();
    drive(1'b1, 1'b0, '0);
    smp();
    chk("first_req", 32'(bus.inst_req), 32'd1);
    chk("first_valid0", 32'(inst_valid_o), 32'd0);
    chk("nomap_req", 32'(bus1.inst_req), 32'd1);
    chk("nomap_addr", bus1.inst_addr, 32'h8000_1000);
    chk("nomap_valid", 32'(inst_valid_o1), 32'd0);
    chk("nomap_inst", inst_o1, 32'd0);
    cyc();
    drive(1'b0, 1'b1, 32'h2408_0001);
    smp();
    chk("first_valid", 32'(inst_valid_o), 32'd1);
    cyc();
    drive(1'b0, 1'b0, '0);

    // held pc served from the result register
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("hold_valid", 32'(inst_valid_o), 32'd1);
      chk("hold_req", 32'(bus.inst_req), 32'd0);
      chk("hold_inst", inst_o, 32'h2408_0001);
      cyc();
    end

    // back-pressure on kseg0 address
    pc = 32'h8000_1000;
    exp_addr.push_back(32'h0000_1000);
    push_inst(32'h8000_1000, 32'h8C09_0010);
    smp();
    chk("bp_miss_valid", 32'(inst_valid_o), 32'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, 1'b0, '0);
      smp();
      chk("bp_req", 32'(bus.inst_req), 32'd1);
      chk("bp_addr", bus.inst_addr, 32'h0000_1000);
      chk("bp_valid", 32'(inst_valid_o), 32'd0);
      cyc();
    end
    drive(1'b0, 1'b0, '0);
    smp();
    chk("bp_wait_valid", 32'(inst_valid_o), 32'd0);
    cyc();
    drive(1'b0, 1'b1, 32'h8C09_0010);
    smp();
    chk("bp_data_valid", 32'(inst_valid_o), 32'd1);
    cyc();
    drive(1'b0, 1'b0, '0);

    // redirect while waiting for data
    pc = 32'hBFC0_0004;
    exp_addr.push_back(32'h1FC0_0004);
    smp();
    cyc();
    drive(1'b1, 1'b0, '0);
    smp();
    cyc();
    drive(1'b0, 1'b0, '0);
    pc = 32'hBFC0_0100;
    exp_addr.push_back(32'h1FC0_0100);
    smp();
    chk("rd_wait_valid", 32'(inst_valid_o), 32'd0);
    cyc();
    drive(1'b0, 1'b1, 32'hDEAD_BEEF);
    smp();
    chk("rd_stale_valid", 32'(inst_valid_o), 32'd0);
    chk("rd_stale_req", 32'(bus.inst_req), 32'd0);
    cyc();
    drive(1'b0, 1'b0, '0);
    pc = 32'hBFC0_0004;
    push_inst(32'hBFC0_0004, 32'hDEAD_BEEF);
    smp();
    chk("rd_req_held", 32'(bus.inst_req), 32'd1);
    chk("rd_req_addr", bus.inst_addr, 32'h1FC0_0100);
    chk("rd_old_tag", 32'(inst_valid_o), 32'd1);
    cyc();
    pc = 32'hBFC0_0100;
    drive(1'b1, 1'b0, '0);
    smp();
    cyc();
    push_inst(32'hBFC0_0100, 32'h3C1D_BFC1);
    drive(1'b0, 1'b1, 32'h3C1D_BFC1);
    smp();
    cyc();
    drive(1'b0, 1'b0, '0);

    // no demand
    pc_en = 1'b0;
    smp();
    chk("noen_valid", 32'(inst_valid_o), 32'd0);
    cyc();
    pc_en = 1'b1;
    push_inst(32'hBFC0_0100, 32'h3C1D_BFC1);
    smp();
    chk("reen_valid", 32'(inst_valid_o), 32'd1);
    chk("reen_req", 32'(bus.inst_req), 32'd0);
    cyc();

    // unmapped low address
    pc = 32'h0040_0000;
    exp_addr.push_back(32'h0040_0000);
    push_inst(32'h0040_0000, 32'h1111_1111);
    smp();
    cyc();
    drive(1'b1, 1'b0, '0);
    smp();
    chk("low_addr", bus.inst_addr, 32'h0040_0000);
    cyc();
    drive(1'b0, 1'b1, 32'h1111_1111);
    smp();
    cyc();
    drive(1'b0, 1'b0, '0);

    // reset while request pending
    pc = 32'hBFC0_0200;
    smp();
    cyc();
    smp();
    chk("rq_pre_req", 32'(bus.inst_req), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    smp();
    chk("rq_rst_req", 32'(bus.inst_req), 32'd0);
    chk("rq_rst_valid", 32'(inst_valid_o), 32'd0);
    exp_addr.push_back(32'h1FC0_0200);
    push_inst(32'hBFC0_0200, 32'h2222_2222);
    cyc();
    drive(1'b1, 1'b0, '0);
    smp();
    chk("rq_fresh_req", 32'(bus.inst_req), 32'd1);
    cyc();
    drive(1'b0, 1'b1, 32'h2222_2222);
    smp();
    cyc();
    drive(1'b0, 1'b0, '0);
    repeat (2) cyc();

    chk("addr_q_empty", 32'(exp_addr.size()), 32'd0);
    chk("inst_q_empty", 32'(exp_inst.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_bridge.md
# inst_mem_bridge

- Sits between the instruction-fetch stage and the instruction memory bus.
- Turns the fetch stage's held `pc`/`pc_en` into single-beat requests on an SRAM-like split bus (req/addr_ok, then data_ok/rdata).
- Returns `inst_o` plus `inst_valid_o`, which the fetch stage uses to hold its stall request.
- Maps kseg0/kseg1 virtual PCs to physical addresses and keeps a one-entry tagged result register, so a held PC is served again without re-issuing.

## Interface
- `ADDR_MAP_EN`, default 1: when 1, kseg0/kseg1 addresses get bits [31:29] cleared; when 0, the address passes through unchanged.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pc` in 32: fetch address from the fetch stage (registered there).
- `pc_en` in 1: fetch wants the instruction at `pc`. 0 means no demand, e.g. misaligned PC or fetch stalled on its buffer.
- `inst_o` out 32: instruction for `pc`.
- `inst_valid_o` out 1: `inst_o` is valid for the current `pc`.
- `inst_req` out 1: bus request.
- `inst_addr` out 32: physical request address.
- `inst_addr_ok` in 1: bus accepted the request this cycle.
- `inst_data_ok` in 1: read data returned this cycle.
- `inst_rdata` in 32: read data.

## Operation
- **Address map:** if `ADDR_MAP_EN` is 1 and `addr[31:30]`==2'b10 (0x8000_0000–0xBFFF_FFFF), then `inst_addr` = {3'b000, addr[28:0]}. Otherwise `inst_addr` = addr.
- **Result register:**
  - Holds `tag_q[31:0]`, `data_q[31:0]` and `vld_q`.
  - hit = `vld_q` && `tag_q`==`pc`.
  - Instruction memory is read-only, so a hit never goes stale.
- **FSM states:** IDLE, REQ, WAIT.
- **IDLE:**
  - `pc_en` && !hit: latch `req_pc`<=`pc`, go to REQ.
  - Otherwise stay in IDLE.
- **REQ:**
  - `inst_req`=1, `inst_addr`=map(`req_pc`).
  - Stay in REQ until `inst_addr_ok`, then go to WAIT.
  - A change of `pc`, or `pc_en` falling, never drops the request. Bus protocol: `req` is held until accepted.
- **WAIT:**
  - `inst_req`=0.
  - On `inst_data_ok`, always write `tag_q`<=`req_pc`, `data_q`<=`inst_rdata`, `vld_q`<=1.
  - Next state is REQ (with `req_pc`<=`pc`) if `pc_en` && `pc`!=`req_pc`; otherwise IDLE.
- **Output bypass (combinational):**
  - If state==WAIT && `inst_data_ok` && `req_pc`==`pc`: `inst_o`=`inst_rdata`, `inst_valid_o`=`pc_en`.
  - Else: `inst_o`=`data_q`, `inst_valid_o`=`pc_en` && hit.
- **No-demand case:** `inst_valid_o` is 0 whenever `pc_en`=0. The fetch stage's own buffer covers that case.
- **Flush/branch:** no dedicated port. A redirect changes `pc`, the tag mismatches, and any in-flight response is stored under its old tag, so it is harmless.
- **At most one outstanding transaction.** `inst_data_ok` seen in IDLE or REQ is ignored.

## Timing
- **Reset values:**
  - state=IDLE, `vld_q`=0, `tag_q`=0, `data_q`=0, `req_pc`=0.
  - `inst_req`=0, `inst_addr`=0, `inst_o`=0, `inst_valid_o`=0.
- **Miss latency:** new `pc` in cycle N, `inst_req` in N+1. With `addr_ok` in N+1 and `data_ok` in N+2, `inst_valid_o`=1 in N+2 (bypass). Each wait cycle on the bus adds one cycle.
- **Hit latency:** `inst_valid_o` in the same cycle `pc` is presented.
- **`inst_req` and `inst_addr`** are driven from registered state/`req_pc` only; no combinational path from `pc`.
- **Simultaneous `data_ok` and `pc` change:** the data is stored under `req_pc`, `inst_valid_o` stays 0, and REQ for the new `pc` follows in the next cycle.
- **Reset mid-transaction:** returns to IDLE immediately. The memory bus shares `rst`, so no stale `data_ok` arrives afterwards.

## Structure
- Shared package holds:
  - FSM state enum (IDLE/REQ/WAIT);
  - kseg constants: KSEG01_HI=2'b10 and the 29-bit offset width;
  - reset PC 0xBFC0_0000, shared with the fetch stage.
- Natural sub-module: `addr_map`, the combinational kseg translation, reused later by the data memory bridge.

## Test plan
- **Reset then first fetch:** `pc`=0xBFC0_0000, `pc_en`=1 → `inst_req` with `inst_addr`=0x1FC0_0000 one cycle later. Bus acks `addr_ok` in that cycle and `data_ok` in the next with rdata=0x2408_0001 → `inst_valid_o`=1 and `inst_o`=0x2408_0001 in that same cycle.
- **Held PC:** `pc` unchanged for 5 cycles after the fill → `inst_valid_o`=1 throughout, no further `inst_req`.
- **Bus back-pressure:** `addr_ok` delayed 3 cycles → `inst_req` and `inst_addr` stay stable for all 4 cycles; the fetch sees `inst_valid_o`=0 until `data_ok`.
- **Redirect while in WAIT:** `pc` changes 0xBFC0_0004 → 0xBFC0_0100 before `data_ok` → no valid for 0x...0100 from the old data. The next request carries `inst_addr`=0x1FC0_0100, and the old data lands in `tag_q`=0xBFC0_0004.
- **Address map:** `pc`=0x8000_1000 → `inst_addr`=0x0000_1000. `pc`=0x0040_0000 → 0x0040_0000. With `ADDR_MAP_EN`=0, 0x8000_1000 passes through unchanged.
- **Reset during REQ:** `rst` pulsed for 1 cycle → next cycle `inst_req`=0, `inst_valid_o`=0, state IDLE. A later `pc_en`=1 gets a fresh request.
